program_loader: RTL and testbench

//  Assembles UART RX bytes into 32-bit instruction words and writes them into MIPS instruction memory.

---
 rtl/program_loader_pkg.sv | 26 ++
 rtl/program_loader_byte_to_word_packer.sv | 57 +++++
 rtl/program_loader.sv | 210 +++++++++++++++++++++
 tb/tb_program_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the UART-to-instruction-memory program loader:
// FSM state encoding, default geometry and the HALT instruction constant.
package program_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    localparam int NB_DATA_DEF        = 32;
    localparam int NB_BYTE_DEF        = 8;
    localparam int NB_MEM_ADDRESS_DEF = 7;

    // MIPS end-of-program instruction: opcode 6'b111111, all other fields zero
    localparam logic [5:0]  HALT_OPCODE   = 6'b111111;
    localparam logic [31:0] HALT_WORD_DEF = {HALT_OPCODE, 26'd0};

    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(NB_DATA_DEF, NB_BYTE_DEF);

endpackage

// File: rtl/program_loader_byte_to_word_packer.sv
// Big-endian byte-to-word packer: the first byte of each group lands in the
// MSB. o_word_ready pulses (combinationally) on the strobe that completes a
// word, with o_word holding the complete word in that same cycle.
module program_loader_byte_to_word_packer
    import program_loader_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_BYTE = NB_BYTE_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic [NB_BYTE-1:0] i_byte,
    input  logic               i_byte_valid,
    output logic [NB_DATA-1:0] o_word,
    output logic               o_word_ready
);

    localparam int BPW    = bytes_per_word(NB_DATA, NB_BYTE);
    localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(BPW - 1);

    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;

    // Shift the new byte in from the right; clear drops any partial word
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        o_word_ready = 1'b0;
        o_word       = {shift_q[NB_DATA-NB_BYTE-1:0], i_byte};
        if (i_clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (i_byte_valid) begin
            shift_d = o_word;
            if (cnt_q == LAST_BYTE) begin
                cnt_d        = '0;
                o_word_ready = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Packer state registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: assembles UART RX bytes into instruction words and writes
// them into instruction memory until the HALT word, or sweeps the memory
// to zero on a delete command.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte after HALT and the o_checksum_error output.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                 NB_DATA        = NB_DATA_DEF,
    parameter int                 NB_BYTE        = NB_BYTE_DEF,
    parameter int                 NB_MEM_ADDRESS = NB_MEM_ADDRESS_DEF,
    parameter logic [NB_DATA-1:0] HALT_WORD      = HALT_WORD_DEF
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start_load,
    input  logic                      i_delete,
    input  logic [NB_BYTE-1:0]        i_rx_byte,
    input  logic                      i_rx_byte_valid,
    output logic                      o_write_enable,
    output logic [NB_MEM_ADDRESS-1:0] o_write_address,
    output logic [NB_DATA-1:0]        o_write_data,
    output logic                      o_program_loaded,
    output logic                      o_overflow,
    output logic                      o_busy
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,output logic                     o_checksum_error
`endif
);

    localparam int NB_ADDR_CNT = NB_MEM_ADDRESS + 1;
    localparam int DEPTH       = 2 ** NB_MEM_ADDRESS;
    localparam logic [NB_ADDR_CNT-1:0] LAST_ADDR = NB_ADDR_CNT'(DEPTH - 1);
    localparam logic [NB_ADDR_CNT-1:0] END_ADDR  = NB_ADDR_CNT'(DEPTH);

    state_e                    state_q, state_d;
    // One extra bit so the counter reaches DEPTH instead of wrapping to 0
    logic [NB_ADDR_CNT-1:0]    addr_q, addr_d;
    logic                      we_q, we_d;
    logic [NB_MEM_ADDRESS-1:0] waddr_q, waddr_d;
    logic [NB_DATA-1:0]        wdata_q, wdata_d;
    logic                      loaded_q, loaded_d;
    logic                      ovf_q, ovf_d;

    logic                      pk_clear, pk_valid, pk_ready;
    logic [NB_DATA-1:0]        pk_word;
    logic                      do_clear, do_start;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0]        csum_q, csum_d;
    logic                      wait_csum_q, wait_csum_d;
    logic                      csum_err_q, csum_err_d;
`endif

    program_loader_byte_to_word_packer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_packer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (pk_clear),
        .i_byte       (i_rx_byte),
        .i_byte_valid (pk_valid),
        .o_word       (pk_word),
        .o_word_ready (pk_ready)
    );

    // Delete beats start, and neither is honoured while a sweep runs
    assign do_clear = i_delete && (state_q != ST_CLEAR);
    assign do_start = i_start_load && (state_q == ST_IDLE || state_q == ST_DONE);

    // Next-state, write-port and flag logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        loaded_d = loaded_q;
        ovf_d    = ovf_q;
        pk_clear = 1'b0;
        pk_valid = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
        wait_csum_d = wait_csum_q;
        csum_err_d  = csum_err_q;
`endif
        if (do_clear) begin
            // Address 0 is written on the entry edge, so the counter resumes at 1
            state_d  = ST_CLEAR;
            we_d     = 1'b1;
            waddr_d  = '0;
            wdata_d  = '0;
            addr_d   = NB_ADDR_CNT'(1);
            loaded_d = 1'b0;
            pk_clear = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            wait_csum_d = 1'b0;
`endif
        end else if (do_start) begin
            state_d  = ST_LOAD;
            addr_d   = '0;
            loaded_d = 1'b0;
            ovf_d    = 1'b0;
            pk_clear = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_d      = '0;
            wait_csum_d = 1'b0;
            csum_err_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_LOAD: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    if (wait_csum_q) begin
                        // The byte after HALT is the XOR of every program byte
                        if (i_rx_byte_valid) begin
                            state_d     = ST_DONE;
                            wait_csum_d = 1'b0;
                            loaded_d    = (i_rx_byte == csum_q);
                            csum_err_d  = (i_rx_byte != csum_q);
                        end
                    end else begin
                        pk_valid = i_rx_byte_valid;
                        if (i_rx_byte_valid) csum_d = csum_q ^ i_rx_byte;
                    end
`else
                    pk_valid = i_rx_byte_valid;
`endif
                    if (pk_ready) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q[NB_MEM_ADDRESS-1:0];
                        wdata_d = pk_word;
                        addr_d  = addr_q + 1'b1;
                        if (pk_word == HALT_WORD) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            wait_csum_d = 1'b1;
`else
                            state_d  = ST_DONE;
                            loaded_d = 1'b1;
`endif
                        end else if (addr_q == LAST_ADDR) begin
                            state_d  = ST_DONE;
                            ovf_d    = 1'b1;
                            loaded_d = 1'b0;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (addr_q == END_ADDR) begin
                        state_d = ST_IDLE;
                        addr_d  = '0;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = addr_q[NB_MEM_ADDRESS-1:0];
                        wdata_d = '0;
                        addr_d  = addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs; reset drops the write strobe immediately
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            loaded_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            loaded_q <= loaded_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Checksum accumulator and result flag
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            csum_q      <= '0;
            wait_csum_q <= 1'b0;
            csum_err_q  <= 1'b0;
        end else begin
            csum_q      <= csum_d;
            wait_csum_q <= wait_csum_d;
            csum_err_q  <= csum_err_d;
        end
    end

    assign o_checksum_error = csum_err_q;
`endif

    assign o_write_enable   = we_q;
    assign o_write_address  = waddr_q;
    assign o_write_data     = wdata_q;
    assign o_program_loaded = loaded_q;
    assign o_overflow       = ovf_q;
    assign o_busy           = (state_q == ST_LOAD) || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of single-word loads,
// randomized programs against a word-list model, and hand-written
// sequences for overflow, clear sweep, abort and reset corner cases.
module tb_program_loader;

    localparam int          DEPTH = 128;
    localparam logic [31:0] HALT  = 32'hFC000000;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start_load = 1'b0;
    logic        i_delete = 1'b0;
    logic [7:0]  i_rx_byte = 8'h00;
    logic        i_rx_byte_valid = 1'b0;
    logic        o_write_enable;
    logic [6:0]  o_write_address;
    logic [31:0] o_write_data;
    logic        o_program_loaded, o_overflow, o_busy;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic        o_checksum_error;
`endif

    always #5 i_clock = ~i_clock;

    program_loader dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_start_load     (i_start_load),
        .i_delete         (i_delete),
        .i_rx_byte        (i_rx_byte),
        .i_rx_byte_valid  (i_rx_byte_valid),
        .o_write_enable   (o_write_enable),
        .o_write_address  (o_write_address),
        .o_write_data     (o_write_data),
        .o_program_loaded (o_program_loaded),
        .o_overflow       (o_overflow),
        .o_busy           (o_busy)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,.o_checksum_error (o_checksum_error)
`endif
    );

    typedef struct {
        int          cyc;
        logic [6:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [3:0][7:0] bytes;   // bytes[3] is sent first
        logic [31:0]     word;
        logic            loaded;
        logic            busy;
    } vec_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    logic exp_loaded, exp_ovf;

    always @(posedge i_clock) cyc <= cyc + 1;

    // Write monitor, sampled mid-cycle
    always @(negedge i_clock) begin
        if (o_write_enable) got_q.push_back('{cyc, o_write_address, o_write_data});
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step(2);
        i_reset = 1'b0;
        step(1);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_byte = b;
        i_rx_byte_valid = 1'b1;
        step(1);
        i_rx_byte_valid = 1'b0;
        i_rx_byte = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8]);
            step($urandom_range(0, maxgap));
        end
    endtask

    task automatic pulse_start();
        i_start_load = 1'b1;
        step(1);
        i_start_load = 1'b0;
    endtask

    task automatic pulse_delete();
        i_delete = 1'b1;
        step(1);
        i_delete = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max, output int n);
        n = 0;
        while (o_busy && n < max) begin
            step(1);
            n++;
        end
        chk({name, " busy timeout"}, 64'(o_busy), 64'(0));
    endtask

    // Compare observed writes against the model's list, then flush both
    task automatic cmp_writes(input string name);
        int m;
        chk({name, " write count"}, 64'(got_q.size()), 64'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s addr[%0d]", name, i), 64'(got_q[i].a), 64'(exp_q[i].a));
            chk($sformatf("%s data[%0d]", name, i), 64'(got_q[i].d), 64'(exp_q[i].d));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Reference: memory receives words in order from address 0 until HALT
    // (inclusive) or until the memory is full.
    task automatic model_load(input logic [31:0] words[$]);
        exp_loaded = 1'b0;
        exp_ovf    = 1'b0;
        for (int i = 0; i < words.size(); i++) begin
            exp_q.push_back('{0, 7'(i), words[i]});
            if (words[i] == HALT) begin
                exp_loaded = 1'b1;
                break;
            end
            if (i == DEPTH - 1) begin
                exp_ovf = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [7:0] xor_bytes(input logic [31:0] words[$]);
        logic [7:0] x = 8'h00;
        foreach (words[i]) x = x ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
        return x;
    endfunction

    vec_t vecs[5];

    initial begin
        logic [31:0] ws[$];
        logic [31:0] w;
        int n;

        vecs[0] = '{32'h20010005, 32'h20010005, 1'b0, 1'b1};
        vecs[1] = '{32'hFC000000, 32'hFC000000, 1'b1, 1'b0};
        vecs[2] = '{32'hFC000001, 32'hFC000001, 1'b0, 1'b1};
        vecs[3] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1};
        vecs[4] = '{32'h7C000000, 32'h7C000000, 1'b0, 1'b1};

        // Reset state
        step(1);
        chk("reset we", 64'(o_write_enable), 64'(0));
        chk("reset addr", 64'(o_write_address), 64'(0));
        chk("reset data", 64'(o_write_data), 64'(0));
        chk("reset loaded", 64'(o_program_loaded), 64'(0));
        chk("reset ovf", 64'(o_overflow), 64'(0));
        chk("reset busy", 64'(o_busy), 64'(0));
        do_reset();

        // Table: one word per load, big-endian assembly and HALT detection
        foreach (vecs[k]) begin
            do_reset();
            pulse_start();
            for (int i = 3; i >= 0; i--) send_byte(vecs[k].bytes[i]);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (vecs[k].loaded) send_byte(vecs[k].bytes[3] ^ vecs[k].bytes[2] ^ vecs[k].bytes[1] ^ vecs[k].bytes[0]);
`endif
            step(2);
            chk($sformatf("vec%0d count", k), 64'(got_q.size()), 64'(1));
            if (got_q.size() > 0) begin
                chk($sformatf("vec%0d addr", k), 64'(got_q[0].a), 64'(0));
                chk($sformatf("vec%0d data", k), 64'(got_q[0].d), 64'(vecs[k].word));
            end
            chk($sformatf("vec%0d loaded", k), 64'(o_program_loaded), 64'(vecs[k].loaded));
            chk($sformatf("vec%0d busy", k), 64'(o_busy), 64'(vecs[k].busy));
        end

        // Basic two-word program, including write latency of one cycle
        do_reset();
        pulse_start();
        send_byte(8'h20); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h05);
        chk("latency we", 64'(o_write_enable), 64'(1));
        chk("latency data", 64'(o_write_data), 64'(32'h20010005));
        step(1);
        chk("strobe one cycle", 64'(o_write_enable), 64'(0));
        send_word(HALT, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h20 ^ 8'h01 ^ 8'h05 ^ 8'hFC);
`endif
        step(2);
        ws = '{32'h20010005, HALT};
        model_load(ws);
        cmp_writes("basic");
        chk("basic loaded", 64'(o_program_loaded), 64'(1));
        chk("basic ovf", 64'(o_overflow), 64'(0));

        // Randomized programs, with stray bytes before start and after HALT
        for (int it = 0; it < 6; it++) begin
            do_reset();
            repeat ($urandom_range(0, 3)) send_byte(8'($urandom));
            pulse_start();
            ws.delete();
            n = $urandom_range(0, 30);
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                if (w == HALT) w = w ^ 32'h1;
                ws.push_back(w);
            end
            ws.push_back(HALT);
            foreach (ws[i]) send_word(ws[i], 2);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            send_byte(xor_bytes(ws));
`endif
            send_word($urandom, 1);
            step(2);
            model_load(ws);
            cmp_writes($sformatf("rand%0d", it));
            chk($sformatf("rand%0d loaded", it), 64'(o_program_loaded), 64'(exp_loaded));
            chk($sformatf("rand%0d busy", it), 64'(o_busy), 64'(0));
        end

        // Overflow: memory filled with no HALT
        do_reset();
        pulse_start();
        ws.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            ws.push_back(w);
        end
        foreach (ws[i]) send_word(ws[i], 0);
        step(2);
        model_load(ws);
        cmp_writes("ovf");
        chk("ovf flag", 64'(o_overflow), 64'(exp_ovf));
        chk("ovf loaded", 64'(o_program_loaded), 64'(0));
        chk("ovf busy", 64'(o_busy), 64'(0));

        // Clear sweep from DONE: contiguous zero writes over the whole memory
        pulse_delete();
        wait_idle("clear", 300, n);
        chk("clear busy cycles", 64'(n), 64'(DEPTH));
        if (got_q.size() == DEPTH)
            chk("clear contiguous", 64'(got_q[DEPTH-1].cyc - got_q[0].cyc), 64'(DEPTH - 1));
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('{0, 7'(i), 32'h0});
        cmp_writes("clear");
        chk("clear loaded", 64'(o_program_loaded), 64'(0));

        // Delete after two bytes: partial word dropped, sweep starts next cycle
        do_reset();
        pulse_start();
        send_byte(8'hAB); send_byte(8'hCD);
        pulse_delete();
        chk("abort we", 64'(o_write_enable), 64'(1));
        chk("abort addr", 64'(o_write_address), 64'(0));
        chk("abort data", 64'(o_write_data), 64'(0));
        wait_idle("abort", 300, n);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('{0, 7'(i), 32'h0});
        cmp_writes("abort");
        pulse_start();
        send_word(32'h12345678, 1);
        send_word(HALT, 1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'hFC);
`endif
        step(2);
        ws = '{32'h12345678, HALT};
        model_load(ws);
        cmp_writes("after abort");

        // Reset mid-LOAD, on the cycle a write is being presented
        do_reset();
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        #2;
        i_reset = 1'b1;
        #1;
        chk("rst load we", 64'(o_write_enable), 64'(0));
        chk("rst load addr", 64'(o_write_address), 64'(0));
        chk("rst load data", 64'(o_write_data), 64'(0));
        chk("rst load busy", 64'(o_busy), 64'(0));
        chk("rst load loaded", 64'(o_program_loaded), 64'(0));
        chk("rst load ovf", 64'(o_overflow), 64'(0));
        step(1);
        i_reset = 1'b0;
        step(1);
        got_q.delete();
        pulse_start();
        send_word(32'h0badf00d, 0);
        send_word(HALT, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h0b ^ 8'had ^ 8'hf0 ^ 8'h0d ^ 8'hFC);
`endif
        step(2);
        ws = '{32'h0badf00d, HALT};
        model_load(ws);
        cmp_writes("rst reload");

        // Reset mid-CLEAR
        pulse_delete();
        step(5);
        #2;
        i_reset = 1'b1;
        #1;
        chk("rst clear we", 64'(o_write_enable), 64'(0));
        chk("rst clear busy", 64'(o_busy), 64'(0));
        step(1);
        i_reset = 1'b0;
        step(1);
        got_q.delete();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Checksum byte after HALT: good then bad
        pulse_start();
        send_word(HALT, 0);
        step(1);
        chk("csum wait busy", 64'(o_busy), 64'(1));
        chk("csum wait loaded", 64'(o_program_loaded), 64'(0));
        send_byte(8'hFC);
        step(1);
        chk("csum good loaded", 64'(o_program_loaded), 64'(1));
        chk("csum good err", 64'(o_checksum_error), 64'(0));
        pulse_start();
        send_word(HALT, 0);
        send_byte(8'h00);
        step(1);
        chk("csum bad loaded", 64'(o_program_loaded), 64'(0));
        chk("csum bad err", 64'(o_checksum_error), 64'(1));
        pulse_start();
        chk("csum err cleared", 64'(o_checksum_error), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
